// File: rtl/cordic_pkg.sv
// cordic_pkg -- shared constants for the pipelined CORDIC.
//   cordic_mode_e : rotation / vectoring selector carried with each sample
//   PI_HALF       : +pi/2 as a 32-bit binary angle (2^32 == 2*pi)
//   K_INV         : 1/K (about 0.6073) in Q0.15, for callers prescaling x/y
//   ATAN_TABLE    : atan(2^-i), i = 0..31, as 32-bit binary angles
//   scale_angle() : rounds a 32-bit binary angle down to an aw-bit one
package cordic_pkg;

  typedef enum logic {
    MODE_ROT = 1'b0,
    MODE_VEC = 1'b1
  } cordic_mode_e;

  localparam logic [31:0] PI_HALF = 32'h4000_0000;

  localparam logic signed [15:0] K_INV = 16'sd19898;

  // round(atan(2^-i) * 2^31 / pi)
  localparam logic [31:0] ATAN_TABLE [0:31] = '{
    32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
    32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
    32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
    32'd166886,    32'd83443,     32'd41722,     32'd20861,
    32'd10430,     32'd5215,      32'd2608,      32'd1304,
    32'd652,       32'd326,       32'd163,       32'd81,
    32'd41,        32'd20,        32'd10,        32'd5,
    32'd3,         32'd1,         32'd1,         32'd0
  };

  // Round-half-up reduction of a 32-bit binary angle to aw bits.
  function automatic logic [31:0] scale_angle(input logic [31:0] a32, input int aw);
    logic [32:0] t;
    if (aw >= 32) return a32;
    t = {1'b0, a32} + (33'd1 << (31 - aw));
    return 32'(t >> (32 - aw));
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// cordic_stage -- one registered CORDIC micro-rotation by atan(2^-SHIFT).
//   clk, rst        : clock, synchronous active-high reset (valid always,
//                     data only when RST_DATA is set)
//   en              : stage enable; everything holds when low
//   in_valid/mode/x/y/z  : sample entering the stage
//   out_valid/mode/x/y/z : registered sample leaving the stage
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int DATA_W   = 18,
  parameter int ANGLE_W  = 16,
  parameter int SHIFT    = 0,
  parameter bit RST_DATA = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      in_valid,
  input  logic                      in_mode,
  input  logic signed [DATA_W-1:0]  in_x,
  input  logic signed [DATA_W-1:0]  in_y,
  input  logic signed [ANGLE_W-1:0] in_z,
  output logic                      out_valid,
  output logic                      out_mode,
  output logic signed [DATA_W-1:0]  out_x,
  output logic signed [DATA_W-1:0]  out_y,
  output logic signed [ANGLE_W-1:0] out_z
);

  localparam logic signed [ANGLE_W-1:0] ATAN_I =
    ANGLE_W'(scale_angle(ATAN_TABLE[SHIFT], ANGLE_W));

  logic signed [DATA_W-1:0]  x_sh, y_sh, x_nxt, y_nxt;
  logic signed [ANGLE_W-1:0] z_nxt;
  logic                      d_pos;

  always_comb begin
    x_sh  = in_x >>> SHIFT;
    y_sh  = in_y >>> SHIFT;
    // Rotation drives z toward 0; vectoring drives y toward 0.
    d_pos = (in_mode == MODE_VEC) ? in_y[DATA_W-1] : !in_z[ANGLE_W-1];
    if (d_pos) begin
      x_nxt = in_x - y_sh;
      y_nxt = in_y + x_sh;
      z_nxt = in_z - ATAN_I;
    end else begin
      x_nxt = in_x + y_sh;
      y_nxt = in_y - x_sh;
      z_nxt = in_z + ATAN_I;
    end
  end

  // ---- stage register ----
  always_ff @(posedge clk) begin
    if (rst)     out_valid <= 1'b0;
    else if (en) out_valid <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (RST_DATA && rst) begin
      out_mode <= 1'b0;
      out_x    <= '0;
      out_y    <= '0;
      out_z    <= '0;
    end else if (en) begin
      out_mode <= in_mode;
      out_x    <= x_nxt;
      out_y    <= y_nxt;
      out_z    <= z_nxt;
    end
  end

endmodule

// File: rtl/cordic_pipe.sv
// cordic_pipe -- fully pipelined CORDIC, rotation and vectoring modes.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake; in_mode 0 = rotate, 1 = vector
//   in_x, in_y [WIDTH]  : signed operands; in_z [ANGLE_W] binary angle
//   out_valid/out_ready : output handshake
//   out_mode, out_x/out_y [WIDTH+2], out_z [ANGLE_W] : registered result,
//                         x/y carry the CORDIC gain K (~1.6468)
// Latency is STAGES+1 enabled cycles; a stalled output freezes every stage.
module cordic_pipe
  import cordic_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ANGLE_W = 16,
  parameter int STAGES  = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_mode,
  input  logic signed [WIDTH-1:0]   in_x,
  input  logic signed [WIDTH-1:0]   in_y,
  input  logic signed [ANGLE_W-1:0] in_z,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_mode,
  output logic signed [WIDTH+1:0]   out_x,
  output logic signed [WIDTH+1:0]   out_y,
  output logic signed [ANGLE_W-1:0] out_z
);

  localparam int XW = WIDTH + 2;
  localparam logic signed [ANGLE_W-1:0] PI_HALF_A =
    ANGLE_W'(scale_angle(PI_HALF, ANGLE_W));

  logic en;
  assign in_ready = !(out_valid && !out_ready);
  assign en       = in_ready;

  logic signed [XW-1:0]      x_ext, y_ext, x_pre, y_pre;
  logic signed [ANGLE_W-1:0] z_pre;

  assign x_ext = {{2{in_x[WIDTH-1]}}, in_x};
  assign y_ext = {{2{in_y[WIDTH-1]}}, in_y};

  // Quadrant fold so the iterations only ever see |angle| < pi/2.
  always_comb begin
    x_pre = x_ext;
    y_pre = y_ext;
    z_pre = in_z;
    if (in_mode == MODE_ROT) begin
      if (in_z >= PI_HALF_A) begin
        x_pre = -y_ext;
        y_pre = x_ext;
        z_pre = in_z - PI_HALF_A;
      end else if (in_z < -PI_HALF_A) begin
        x_pre = y_ext;
        y_pre = -x_ext;
        z_pre = in_z + PI_HALF_A;
      end
    end else if (x_ext[XW-1]) begin
      if (!y_ext[XW-1]) begin
        x_pre = y_ext;
        y_pre = -x_ext;
        z_pre = in_z + PI_HALF_A;
      end else begin
        x_pre = -y_ext;
        y_pre = x_ext;
        z_pre = in_z - PI_HALF_A;
      end
    end
  end

  // ---- p0: pre-rotation register ----
  logic                      vld_p0, mode_p0;
  logic signed [XW-1:0]      x_p0, y_p0;
  logic signed [ANGLE_W-1:0] z_p0;

  always_ff @(posedge clk) begin
    if (rst)     vld_p0 <= 1'b0;
    else if (en) vld_p0 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mode_p0 <= in_mode;
      x_p0    <= x_pre;
      y_p0    <= y_pre;
      z_p0    <= z_pre;
    end
  end

  // ---- pk: iteration stages; the last one is the output register ----
  logic                      vld_pk  [0:STAGES];
  logic                      mode_pk [0:STAGES];
  logic signed [XW-1:0]      x_pk    [0:STAGES];
  logic signed [XW-1:0]      y_pk    [0:STAGES];
  logic signed [ANGLE_W-1:0] z_pk    [0:STAGES];

  assign vld_pk[0]  = vld_p0;
  assign mode_pk[0] = mode_p0;
  assign x_pk[0]    = x_p0;
  assign y_pk[0]    = y_p0;
  assign z_pk[0]    = z_p0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cordic_stage #(
      .DATA_W   (XW),
      .ANGLE_W  (ANGLE_W),
      .SHIFT    (k),
      .RST_DATA (k == STAGES - 1)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (vld_pk[k]),
      .in_mode   (mode_pk[k]),
      .in_x      (x_pk[k]),
      .in_y      (y_pk[k]),
      .in_z      (z_pk[k]),
      .out_valid (vld_pk[k+1]),
      .out_mode  (mode_pk[k+1]),
      .out_x     (x_pk[k+1]),
      .out_y     (y_pk[k+1]),
      .out_z     (z_pk[k+1])
    );
  end

  assign out_valid = vld_pk[STAGES];
  assign out_mode  = mode_pk[STAGES];
  assign out_x     = x_pk[STAGES];
  assign out_y     = y_pk[STAGES];
  assign out_z     = z_pk[STAGES];

endmodule
